serial_config_shift_register: RTL and testbench

- Serial-in/parallel-out configuration register loaded by software through GPIO bit-banging.
- Used in the RF data path, e.g. the ADC cycle-count and shift-value registers.
- A slow software-driven serial clock (sclk) and data bit (data_in) are sampled in the rf_clk domain.
- Each detected sclk rising edge shifts one bit in; the full register drives a static parallel output consumed by rf_clk logic.

---
 rtl/serial_config_shift_register_if.sv | 24 ++
 rtl/serial_config_shift_register.sv | 44 ++++
 tb/tb_serial_config_shift_register.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_config_shift_register_if.sv
// Bundle of the GPIO-driven serial load lines and the parallel config word.
// There is no valid/ready handshake on this bundle: sclk/data_in are raw
// asynchronous GPIO bits, and data_out is always valid.
interface serial_config_shift_register_if #(
    parameter int WIDTH = 32
);
    logic             sclk;
    logic             data_in;
    logic [WIDTH-1:0] data_out;

    // Software/GPIO side drives the serial lines and observes the word
    modport master (
        output sclk,
        output data_in,
        input  data_out
    );

    // Config register side
    modport slave (
        input  sclk,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/serial_config_shift_register.sv
// Serial-in/parallel-out configuration register, bit-banged by software.
// sclk and data_in are synchronized into rf_clk through identical chains so
// bits written by the same GPIO write stay aligned. Each rising edge of the
// synchronized sclk shifts one bit in at the LSB (MSB-first protocol).
// sclk is only ever sampled as data, never used as a clock.
// SYNC_STAGES must be at least 2.
module serial_config_shift_register #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            rf_clk,
    input  logic                            rf_reset,
    serial_config_shift_register_if.slave   cfg
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sclk_prev;
    logic [WIDTH-1:0]       shift_reg;
    logic                   sclk_rise;

    // A held-high sclk rises only once, so it yields exactly one shift
    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;

    // Synchronizers, edge history and the shift register share one async-reset block
    always_ff @(posedge rf_clk or negedge rf_reset) begin
        if (!rf_reset) begin
            sclk_sync <= '0;
            data_sync <= '0;
            sclk_prev <= 1'b0;
            shift_reg <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], cfg.sclk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], cfg.data_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            if (sclk_rise) begin
                shift_reg <= {shift_reg[WIDTH-2:0], data_sync[SYNC_STAGES-1]};
            end
        end
    end

    assign cfg.data_out = shift_reg;

endmodule

// File: tb/tb_serial_config_shift_register.sv
// Directed bench for serial_config_shift_register: reset, full/short loads,
// overflow, hold rule, latency and mid-sequence reset.
`timescale 1ns/1ps
module tb_serial_config_shift_register;

    localparam int WIDTH       = 32;
    localparam int SYNC_STAGES = 2;

    logic rf_clk   = 1'b0;
    logic rf_reset = 1'b0;

    serial_config_shift_register_if #(.WIDTH(WIDTH)) cfg_if ();

    serial_config_shift_register #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .rf_clk   (rf_clk),
        .rf_reset (rf_reset),
        .cfg      (cfg_if.slave)
    );

    // ---------------- clock / watchdog ----------------
    always #5 rf_clk = ~rf_clk;

    int checks   = 0;
    int failures = 0;

    initial begin
        #200us;
        failures++;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare data_out against the oldest expected word
    task automatic score(input string tag);
        logic [WIDTH-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got=%h exp=<empty queue>", tag, cfg_if.data_out);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, cfg_if.data_out, exp);
        end
    endtask

    // ---------------- driver tasks (drive on falling edge) ----------------
    task automatic apply_reset();
        @(negedge rf_clk);
        cfg_if.sclk    = 1'b0;
        cfg_if.data_in = 1'b0;
        rf_reset       = 1'b0;
        repeat (3) @(negedge rf_clk);
        rf_reset = 1'b1;
        @(negedge rf_clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge rf_clk);
        cfg_if.data_in = b;
        cfg_if.sclk    = 1'b1;
        repeat (4) @(negedge rf_clk);
        cfg_if.sclk = 1'b0;
        repeat (4) @(negedge rf_clk);
    endtask

    // Sends the low n bits of word, most significant first
    task automatic send_word(input logic [WIDTH-1:0] word, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(word[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cfg_if.sclk    = 1'b0;
        cfg_if.data_in = 1'b0;

        // Reset: zero while held and after release with sclk low
        repeat (2) @(negedge rf_clk);
        exp_q.push_back(32'h0);
        score("reset_held");
        rf_reset = 1'b1;
        repeat (5) @(negedge rf_clk);
        exp_q.push_back(32'h0);
        score("reset_released");

        // Full MSB-first load, then stability
        send_word(32'hA5A5_0003, 32);
        exp_q.push_back(32'hA5A5_0003);
        score("full_load");
        repeat (20) @(negedge rf_clk);
        exp_q.push_back(32'hA5A5_0003);
        score("full_load_stable");

        // Short load then overflow with zeros
        apply_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        exp_q.push_back(32'h0000_0003);
        score("short_two_bits");
        send_bit(1'b1);
        exp_q.push_back(32'h0000_0007);
        score("short_three_bits");
        send_word(32'h0, 32);
        exp_q.push_back(32'h0);
        score("overflow_zeros");

        // Hold rule: long high phase gives one shift, falling edge gives none
        apply_reset();
        cfg_if.data_in = 1'b1;
        cfg_if.sclk    = 1'b1;
        repeat (50) @(negedge rf_clk);
        exp_q.push_back(32'h0000_0001);
        score("hold_high_one_shift");
        cfg_if.sclk = 1'b0;
        repeat (10) @(negedge rf_clk);
        exp_q.push_back(32'h0000_0001);
        score("hold_fall_no_shift");

        // Latency: raise at a falling edge; the next rising edge samples it.
        // Update lands on the third edge counting that sampling edge.
        apply_reset();
        cfg_if.data_in = 1'b1;
        cfg_if.sclk    = 1'b1;
        @(negedge rf_clk);
        exp_q.push_back(32'h0);
        score("latency_edge1");
        @(negedge rf_clk);
        exp_q.push_back(32'h0);
        score("latency_edge2");
        @(negedge rf_clk);
        exp_q.push_back(32'h0000_0001);
        score("latency_edge3");
        repeat (3) @(negedge rf_clk);
        cfg_if.sclk = 1'b0;
        repeat (4) @(negedge rf_clk);

        // Mid-sequence reset: partial word lost immediately, then a clean load
        apply_reset();
        send_word(32'hA5A5_0003 >> 22, 10);
        exp_q.push_back(32'h0000_0296);
        score("partial_10_bits");
        @(negedge rf_clk);
        rf_reset = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        score("async_reset_clear");
        rf_reset = 1'b1;
        repeat (2) @(negedge rf_clk);
        send_word(32'h1234_5678, 32);
        exp_q.push_back(32'h1234_5678);
        score("reload_after_reset");

        // ---------------- final report ----------------
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_expect: got=%0d entries exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
